// File: rtl/clk_int_div_mon_pkg.sv
// rtl/clk_int_div_mon_pkg.sv - shared state encoding and default widths for the divider monitor
package clk_int_div_mon_pkg;

  localparam int DEF_CNT_WIDTH   = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/clk_mon_sync.sv
// rtl/clk_mon_sync.sv - multi-flop synchronizer bringing the monitored clock into the reference domain
module clk_mon_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES:0] w_chain;

  assign w_chain[0] = i_async;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    dffr #(.W(1)) u_ff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (w_chain[g]),
      .o_q   (w_chain[g+1])
    );
  end

  assign o_sync = w_chain[STAGES];

endmodule

// File: rtl/dffr.sv
// rtl/dffr.sv - register with active-high asynchronous clear to zero
module dffr #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_q <= '0;
    else       o_q <= i_d;
  end

endmodule

// File: rtl/clk_int_div_mon.sv
// rtl/clk_int_div_mon.sv - measures period and high time of a divided clock against an expected setting
module clk_int_div_mon
  import clk_int_div_mon_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clk_mon_i,
  input  logic [CNT_WIDTH-1:0] exp_div_i,
  input  logic [CNT_WIDTH-1:0] tol_i,
  output logic                 meas_valid_o,
  input  logic                 meas_ready_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 match_o,
  output logic                 timeout_o
);

  logic                 w_sync;
  logic                 r_hist;
  logic                 w_rise;
  logic                 w_fall;
  logic [1:0]           r_state_q;
  state_e               w_state;
  state_e               w_state_d;
  logic [CNT_WIDTH-1:0] r_cnt,    w_cnt_d;
  logic                 r_high_done, w_high_done_d;
  logic                 r_valid,  w_valid_d;
  logic [CNT_WIDTH-1:0] r_period, w_period_d;
  logic [CNT_WIDTH-1:0] r_high,   w_high_d;
  logic                 r_match,  w_match_d;
  logic                 r_timeout, w_timeout_d;
  logic                 w_cnt_max;
  logic signed [CNT_WIDTH:0] w_diff;
  logic [CNT_WIDTH:0]   w_abs;
  logic                 w_match;

  clk_mon_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_async (clk_mon_i),
    .o_sync  (w_sync)
  );

  dffr #(.W(1)) u_hist (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_sync), .o_q(r_hist));

  assign w_rise    = w_sync & ~r_hist;
  assign w_fall    = ~w_sync & r_hist;
  assign w_state   = state_e'(r_state_q);
  assign w_cnt_max = &r_cnt;

  // One extra bit keeps the difference exact for any pair of unsigned operands
  assign w_diff  = $signed({1'b0, r_cnt}) - $signed({1'b0, exp_div_i});
  assign w_abs   = w_diff[CNT_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_match = (w_abs <= {1'b0, tol_i});

  always_comb begin
    w_state_d     = w_state;
    w_cnt_d       = r_cnt;
    w_high_done_d = r_high_done;
    w_period_d    = r_period;
    w_high_d      = r_high;
    w_match_d     = r_match;
    w_timeout_d   = r_timeout;
    if (!en_i) begin
      w_state_d = IDLE;
      w_cnt_d   = '0;
    end else begin
      unique case (w_state)
        IDLE: begin
          w_state_d = ARM;
          w_cnt_d   = '0;
        end
        ARM: begin
          if (w_rise) begin
            w_state_d     = MEAS;
            w_cnt_d       = '0;
            w_high_done_d = 1'b0;
          end else if (w_cnt_max) begin
            w_state_d   = HOLD;
            w_period_d  = '1;
            w_match_d   = 1'b0;
            w_timeout_d = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CNT_WIDTH'(1);
          end
        end
        MEAS: begin
          if (w_rise) begin
            w_state_d   = HOLD;
            w_period_d  = r_cnt;
            w_match_d   = w_match;
            w_timeout_d = 1'b0;
          end else begin
            if (w_fall && !r_high_done) begin
              w_high_d      = r_cnt;
              w_high_done_d = 1'b1;
            end
            if (w_cnt_max) begin
              w_state_d   = HOLD;
              w_period_d  = '1;
              w_match_d   = 1'b0;
              w_timeout_d = 1'b1;
            end else begin
              w_cnt_d = r_cnt + CNT_WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (meas_ready_i) begin
            w_state_d = ARM;
            w_cnt_d   = '0;
          end
        end
      endcase
    end
    w_valid_d = (w_state_d == HOLD);
  end

  dffr #(.W(2))         u_state  (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_state_d),     .o_q(r_state_q));
  dffr #(.W(CNT_WIDTH)) u_cnt    (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_cnt_d),       .o_q(r_cnt));
  dffr #(.W(1))         u_hdone  (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_high_done_d), .o_q(r_high_done));
  dffr #(.W(1))         u_valid  (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_valid_d),     .o_q(r_valid));
  dffr #(.W(CNT_WIDTH)) u_period (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_period_d),    .o_q(r_period));
  dffr #(.W(CNT_WIDTH)) u_high   (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_high_d),      .o_q(r_high));
  dffr #(.W(1))         u_match  (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_match_d),     .o_q(r_match));
  dffr #(.W(1))         u_tmo    (.i_clk(clk_i), .i_rst(rst_i), .i_d(w_timeout_d),   .o_q(r_timeout));

  assign meas_valid_o = r_valid;
  assign period_o     = r_period;
  assign high_o       = r_high;
  assign match_o      = r_match;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_clk_int_div_mon.sv
// tb/tb_clk_int_div_mon.sv - directed vector bench for the divider monitor
module tb_clk_int_div_mon;
  import clk_int_div_mon_pkg::*;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         en_i = 1'b0;
  logic         clk_mon_i = 1'b0;
  logic         meas_ready_i = 1'b0;
  logic [W-1:0] exp_div_i = '0;
  logic [W-1:0] tol_i = '0;
  logic         meas_valid_o;
  logic [W-1:0] period_o;
  logic [W-1:0] high_o;
  logic         match_o;
  logic         timeout_o;

  clk_int_div_mon #(.CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .clk_mon_i    (clk_mon_i),
    .exp_div_i    (exp_div_i),
    .tol_i        (tol_i),
    .meas_valid_o (meas_valid_o),
    .meas_ready_i (meas_ready_i),
    .period_o     (period_o),
    .high_o       (high_o),
    .match_o      (match_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int mon_period = 8;
  int mon_high   = 3;
  bit mon_on     = 1'b0;
  int cyc        = 0;

  // Monitored clock changes just after each reference edge
  always @(posedge clk_i) begin
    #1;
    cyc = cyc + 1;
    clk_mon_i = mon_on && ((cyc % mon_period) < mon_high);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk_i);
      cycles++;
      if (meas_valid_o) ok = 1'b1;
    end
  endtask

  task automatic setup(input int per, input int hi, input logic [W-1:0] ed, input logic [W-1:0] tl);
    en_i = 1'b0;
    meas_ready_i = 1'b0;
    mon_on = 1'b1;
    mon_period = per;
    mon_high = hi;
    exp_div_i = ed;
    tol_i = tl;
    repeat (20) @(negedge clk_i);
  endtask

  typedef struct {
    int         period;
    int         high;
    logic [W-1:0] exp_div;
    logic [W-1:0] tol;
    logic [W-1:0] e_period;
    logic [W-1:0] e_high;
    logic       e_match;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int  cycles;
    bit  ok;
    int  seen;
    logic [2*W+1:0] snap;

    vecs[0] = '{8,   3,   8'd7,   8'd0,   8'd7,   8'd2,  1'b1};
    vecs[1] = '{8,   3,   8'd5,   8'd1,   8'd7,   8'd2,  1'b0};
    vecs[2] = '{8,   3,   8'd5,   8'd2,   8'd7,   8'd2,  1'b1};
    vecs[3] = '{2,   1,   8'd1,   8'd0,   8'd1,   8'd0,  1'b1};
    vecs[4] = '{5,   2,   8'd9,   8'd3,   8'd4,   8'd1,  1'b0};
    vecs[5] = '{200, 100, 8'd199, 8'd0,   8'd199, 8'd99, 1'b1};
    vecs[6] = '{8,   3,   8'd255, 8'd247, 8'd7,   8'd2,  1'b0};
    vecs[7] = '{8,   3,   8'd255, 8'd248, 8'd7,   8'd2,  1'b1};
    vecs[8] = '{8,   3,   8'd0,   8'd6,   8'd7,   8'd2,  1'b0};

    repeat (3) @(negedge clk_i);
    chk("reset_valid",   32'(meas_valid_o), 0);
    chk("reset_period",  32'(period_o), 0);
    chk("reset_high",    32'(high_o), 0);
    chk("reset_match",   32'(match_o), 0);
    chk("reset_timeout", 32'(timeout_o), 0);
    rst_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      setup(vecs[i].period, vecs[i].high, vecs[i].exp_div, vecs[i].tol);
      en_i = 1'b1;
      wait_valid(600, cycles, ok);
      chk($sformatf("v%0d_valid", i),   32'(ok), 1);
      chk($sformatf("v%0d_period", i),  32'(period_o), 32'(vecs[i].e_period));
      chk($sformatf("v%0d_high", i),    32'(high_o), 32'(vecs[i].e_high));
      chk($sformatf("v%0d_match", i),   32'(match_o), 32'(vecs[i].e_match));
      chk($sformatf("v%0d_timeout", i), 32'(timeout_o), 0);
      en_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk($sformatf("v%0d_idle_valid", i),  32'(meas_valid_o), 0);
      chk($sformatf("v%0d_idle_period", i), 32'(period_o), 32'(vecs[i].e_period));
    end

    // Stuck monitored clock: 256 cycles in ARM, then HOLD
    setup(8, 3, 8'd7, 8'd255);
    mon_on = 1'b0;
    repeat (10) @(negedge clk_i);
    en_i = 1'b1;
    wait_valid(400, cycles, ok);
    chk("tmo_valid",   32'(ok), 1);
    chk("tmo_latency", 32'(cycles), 257);
    chk("tmo_timeout", 32'(timeout_o), 1);
    chk("tmo_period",  32'(period_o), 255);
    chk("tmo_match",   32'(match_o), 0);

    // Back-pressure: results frozen, edges in HOLD ignored, fresh measurement after handshake
    setup(8, 3, 8'd7, 8'd0);
    en_i = 1'b1;
    wait_valid(600, cycles, ok);
    chk("stall_valid",  32'(ok), 1);
    chk("stall_period", 32'(period_o), 7);
    snap = {period_o, high_o, match_o, timeout_o};
    mon_period = 6;
    mon_high = 2;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      chk($sformatf("stall_hold%0d", k), 32'({meas_valid_o, period_o, high_o, match_o, timeout_o}),
          32'({1'b1, snap}));
    end
    meas_ready_i = 1'b1;
    @(negedge clk_i);
    meas_ready_i = 1'b0;
    chk("stall_hs_valid", 32'(meas_valid_o), 0);
    wait_valid(600, cycles, ok);
    chk("fresh_valid",  32'(ok), 1);
    chk("fresh_period", 32'(period_o), 5);
    chk("fresh_high",   32'(high_o), 1);
    chk("fresh_match",  32'(match_o), 0);

    // Fastest clock with continuous ready
    setup(2, 1, 8'd1, 8'd0);
    meas_ready_i = 1'b1;
    en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(50, cycles, ok);
      chk($sformatf("b2b%0d_valid", k),  32'(ok), 1);
      chk($sformatf("b2b%0d_period", k), 32'(period_o), 1);
      chk($sformatf("b2b%0d_high", k),   32'(high_o), 0);
    end
    meas_ready_i = 1'b0;

    // Enable dropped mid-measurement
    setup(200, 100, 8'd199, 8'd0);
    en_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk_i);
      if (dut.w_state == MEAS) ok = 1'b1;
    end
    chk("endrop_reached_meas", 32'(ok), 1);
    repeat (50) @(negedge clk_i);
    en_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_i);
      if (meas_valid_o) seen++;
    end
    chk("endrop_no_valid", 32'(seen), 0);
    chk("endrop_idle",     32'(dut.w_state), 32'(IDLE));

    // Reset pulse while a result is held
    setup(8, 3, 8'd7, 8'd0);
    en_i = 1'b1;
    wait_valid(600, cycles, ok);
    chk("rsthold_valid_before", 32'(ok), 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rsthold_valid",  32'(meas_valid_o), 0);
    chk("rsthold_period", 32'(period_o), 0);
    chk("rsthold_high",   32'(high_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rsthold_after", 32'(meas_valid_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_int_div_mon.md
CLK_INT_DIV_MON -- requirements
Module: clk_int_div_mon

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the cycle counter and of every count output.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the clk_mon_i synchronizer.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clk_i  in  1  reference clock.
- rst_i  in  1  asynchronous active-high reset.
REQ-004 SHALL have the remaining ports:
- en_i  in  1  monitor enable.
- clk_mon_i  in  1  monitored clock, asynchronous to clk_i, typically a divider output.
- exp_div_i  in  CNT_WIDTH  expected divider setting; expected period = exp_div_i+1 cycles.
- tol_i  in  CNT_WIDTH  allowed absolute period error in cycles.
- meas_valid_o  out  1  a measurement result is available.
- meas_ready_i  in  1  the consumer accepts the result.
- period_o  out  CNT_WIDTH  measured period minus one, same encoding as a divider setting.
- high_o  out  CNT_WIDTH  measured high time minus one.
- match_o  out  1  |period_o - exp_div_i| <= tol_i.
- timeout_o  out  1  no edge arrived before the counter saturated.

Function
REQ-005 SHALL synchronize clk_mon_i through SYNC_STAGES flops, then through one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-006 SHALL implement FSM states IDLE, ARM, MEAS, HOLD.
REQ-007 SHALL go from IDLE to ARM when en_i=1, clearing the counter.
REQ-008 In ARM, SHALL go to MEAS on rise, clearing the counter.
REQ-009 In MEAS, on fall SHALL capture cnt_q into high_o; only the first fall per measurement is captured.
REQ-010 In MEAS, on rise SHALL capture cnt_q into period_o, compute match_o, set timeout_o=0 and go to HOLD. Two rises t cycles apart therefore give period_o=t-1.
REQ-011 Counter SHALL increment every cycle in ARM and MEAS.
REQ-012 When the counter equals all-ones and no rise occurs that cycle, in ARM or MEAS, SHALL go to HOLD with timeout_o=1, period_o=all-ones, match_o=0.
REQ-013 In HOLD, SHALL hold meas_valid_o=1.
REQ-014 All result outputs SHALL stay stable until a cycle with meas_valid_o=1 and meas_ready_i=1.
REQ-015 On that handshake cycle SHALL go to ARM with the counter cleared, starting a fresh measurement.
REQ-016 Edges arriving in HOLD SHALL be ignored.
REQ-017 en_i=0 SHALL force IDLE on the next cycle from any state; this takes priority over a handshake or a capture in the same cycle.
REQ-018 Result-output values in IDLE: meas_valid_o=0; the other outputs retain their last values.
REQ-019 match_o SHALL be computed from a CNT_WIDTH+1-bit signed difference, with no wrap-around error.
REQ-020 Latency: meas_valid_o SHALL rise exactly one cycle after the rise flag that closes the period.
REQ-021 Correct results SHALL be guaranteed only when the high and low phases of the monitored clock each last at least 1 clk_i period.
REQ-022 The minimum measurable period SHALL be 2 cycles (period_o=1).

Reset
REQ-023 While rst_i=1, SHALL asynchronously set FSM=IDLE, counter=0, synchronizer and history flops=0.
REQ-024 While rst_i=1, SHALL asynchronously set meas_valid_o=0, period_o=0, high_o=0, match_o=0, timeout_o=0.
REQ-025 A reset asserted mid-measurement or in HOLD SHALL discard the result.

Structure
REQ-026 Package clk_int_div_mon_pkg SHALL hold the FSM state enum and the default widths.
REQ-027 The synchronizer SHALL be one sub-module, clk_mon_sync, parameterized by stage count and built from the existing dffr flops.
REQ-028 All other flops SHALL use dffr-style register instances with an active-high asynchronous clear.

Verification
REQ-029 Monitored clock of period 8, high 3; exp_div_i=7, tol_i=0 -> period_o=7, high_o=2, match_o=1, timeout_o=0.
REQ-030 Same clock; exp_div_i=5, tol_i=1 -> match_o=0. Then tol_i=2 -> match_o=1.
REQ-031 CNT_WIDTH=8, clk_mon_i stuck at 0 -> timeout_o=1 and period_o=255 after 256 cycles in ARM.
REQ-032 Hold meas_ready_i=0 for 20 cycles -> all outputs stable. After the handshake, the next result reflects a freshly started measurement.
REQ-033 Drop en_i mid-MEAS -> meas_valid_o never asserts and the FSM is IDLE; pulse rst_i in HOLD -> meas_valid_o=0 immediately.
REQ-034 Period 2, high 1 (fastest clock) -> period_o=1, high_o=0; back-to-back handshakes give identical results.
